mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit and HI/LO register file in the EX stage. It consumes the ALU function code produced by ID for SPECIAL instructions: `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_MTHI`, `FUNCT_MTLO`, `FUNCT_MFHI` and `FUNCT_MFLO`. It runs iterative arithmetic, holds the pipeline with a stall request while busy, and exposes the architectural HI/LO values to the EX result mux.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `CNT_W`, 5, iteration counter width. `2**CNT_W` must equal `WIDTH`.

Ports:
- `clk`: in, 1. Rising-edge clock.
- `rst`: in, 1. Asynchronous, active-low reset.
- `en`: in, 1. An EX instruction is valid this cycle; deasserted for bubbles.
- `funct`: in, `FUNCT_BUS`. Function code from ID, via the ID/EX register.
- `flush`: in, 1. Pipeline flush (exception/eret). Aborts any operation in flight.
- `operand_1`: in, `WIDTH`. rs value (dividend / multiplicand / MTHI-MTLO source).
- `operand_2`: in, `WIDTH`. rt value (divisor / multiplier).
- `stall_req`: out, 1. Hold PC, IF, ID and EX this cycle.
- `hi`: out, `WIDTH`. Architectural HI register.
- `lo`: out, `WIDTH`. Architectural LO register.

## Operation
- **Start condition:** `start = en & ~flush & state==IDLE & funct ∈ {MULT, MULTU, DIV, DIVU}`.
- **States:** IDLE, MUL, DIV, DONE. Encoding is free.
- **IDLE**
  - On `start`, latch the operand magnitudes and the result-sign flags, clear the counter, and go to MUL or DIV.
  - `en & funct==MTHI` → `hi <= operand_1`. `en & funct==MTLO` → `lo <= operand_1`. Both complete in one cycle with no stall.
  - MFHI/MFLO need no action; EX reads `hi`/`lo` directly.
- **Signed handling:** MULT/DIV operate on absolute values.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - `0x80000000` magnitudes are handled as unsigned `2**31`.
- **MUL:** shift-add, one multiplier bit per cycle, into a `2*WIDTH` accumulator. Goes to DONE after the counter wraps from `2**CNT_W-1`.
- **DIV:** restoring radix-2, one quotient bit per cycle. Goes to DONE after `WIDTH` iterations.
  - Divisor == 0 is detected at start and skips directly to DONE with HI = `operand_1`, LO = `0xFFFFFFFF`. No trap is raised.
- **DONE:** `stall_req` = 0. At the closing edge, HI/LO take the sign-corrected result (MUL: HI = upper half, LO = lower half; DIV: HI = remainder, LO = quotient). The FSM then returns to IDLE.
- **`stall_req`:** combinational, equal to `start | state==MUL | state==DIV`.
- **Flush:** in any state, `flush` forces IDLE at the next edge. HI/LO are unchanged and `stall_req` is 0 in that cycle.
- **Reset:** state = IDLE, `hi` = 0, `lo` = 0, counter = 0, `stall_req` = 0.

## Timing
- Cycle 0: IDLE with `start`; `stall_req` = 1.
- Cycles 1..32: iterations; `stall_req` = 1.
- Cycle 33: DONE; `stall_req` = 0; HI/LO update at the end of cycle 33.
- The instruction occupies EX for 34 cycles. An MFHI/MFLO entering EX in cycle 34 reads the new value; no forwarding is required.
- Divide-by-zero: cycle 0 start, cycle 1 DONE, so EX occupancy is 2 cycles.
- `en`/`funct`/operands are held stable by the pipeline while stalled. The unit ignores `funct` in MUL/DIV/DONE, so a held MULT in DONE does not restart.
- MTHI/MTLO updates are visible on `hi`/`lo` in the following cycle.
- Asynchronous reset mid-operation returns the unit to IDLE immediately and drops `stall_req` combinationally.

## Configuration
- `MDU_FAST_MULT_EN` defined: MULT/MULTU use a single-cycle `*` product computed in IDLE. The FSM goes IDLE → DONE, EX occupancy is 2 cycles, and the MUL state is unused. DIV is unchanged.
- Undefined: MULT/MULTU use the 32-iteration MUL state. Results are bit-identical in both builds.

## Test plan
- MULT `0xFFFFFFFF` × `0x00000002` → `stall_req` high for 33 cycles (1 cycle with `MDU_FAST_MULT_EN`), then HI = `0xFFFFFFFF`, LO = `0xFFFFFFFE`. MULTU with the same operands → HI = `0x00000001`, LO = `0xFFFFFFFE`.
- DIV −7 (`0xFFFFFFF9`) ÷ 2 → LO = `0xFFFFFFFD`, HI = `0xFFFFFFFF`. DIVU `0xFFFFFFF9` ÷ 2 → LO = `0x7FFFFFFC`, HI = `0x00000001`.
- DIVU 5 ÷ 0 → `stall_req` high for 1 cycle, HI = `0x00000005`, LO = `0xFFFFFFFF`.
- MTHI `0x12345678`, then MTLO `0x9ABCDEF0`, then DIV `0x80000000` ÷ `0xFFFFFFFF` → MTHI/MTLO values visible with no stall. The DIV leaves LO = `0x80000000`, HI = 0.
- MULT started, `flush` asserted in cycle 10 → state IDLE and `stall_req` = 0 next cycle, with HI/LO still holding their pre-MULT values.
- `rst` asserted low in cycle 5 of a DIV → `stall_req` = 0 immediately, and `hi`/`lo` = 0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// EX-stage multiply/divide bus: function code and operands in, stall request and HI/LO out.
interface mult_div_unit_if #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
);
    logic               en;
    logic [FUNCT_W-1:0] funct;
    logic               flush;
    logic [WIDTH-1:0]   operand_1;
    logic [WIDTH-1:0]   operand_2;
    logic               stall_req;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (output en, funct, flush, operand_1, operand_2,
                    input  stall_req, hi, lo);
    modport slave  (input  en, funct, flush, operand_1, operand_2,
                    output stall_req, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply (shift-add) / restoring divide with HI/LO registers.
// Define MDU_FAST_MULT_EN for a single-cycle multiplier; division stays iterative.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_is_div, r_neg_q, r_neg_r;
    logic [WIDTH-1:0]     r_hi, r_lo;

    logic                 w_is_mul, w_is_div, w_signed, w_start;
    logic                 w_a_neg, w_b_neg, w_div_zero, w_div_ok;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_mul_sum, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_rem, w_quo;

    assign w_is_mul   = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
    assign w_is_div   = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
    assign w_signed   = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    // rst gating keeps stall_req low while reset is held with a valid op on the bus
    assign w_start    = rst && bus.en && !bus.flush && (r_state == S_IDLE) && (w_is_mul || w_is_div);
    assign w_a_neg    = w_signed && bus.operand_1[WIDTH-1];
    assign w_b_neg    = w_signed && bus.operand_2[WIDTH-1];
    assign w_mag_a    = w_a_neg ? -bus.operand_1 : bus.operand_1;
    assign w_mag_b    = w_b_neg ? -bus.operand_2 : bus.operand_2;
    assign w_div_zero = (bus.operand_2 == '0);

    // MUL: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    // DIV: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = !w_div_diff[WIDTH];

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    assign bus.stall_req = w_start || (r_state == S_MUL) || (r_state == S_DIV);
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) begin
                if (w_is_div)
                    w_next = w_div_zero ? S_DONE : S_DIV;
                else
`ifdef MDU_FAST_MULT_EN
                    w_next = S_DONE;
`else
                    w_next = S_MUL;
`endif
            end
            S_MUL:   if (&r_cnt) w_next = S_DONE;
            S_DIV:   if (&r_cnt) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_is_div) begin
                            if (w_div_zero) begin
                                r_acc   <= {bus.operand_1, {WIDTH{1'b1}}};
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                            end else begin
                                r_acc <= {{WIDTH{1'b0}}, w_mag_a};
                                r_opb <= w_mag_b;
                            end
                        end else begin
`ifdef MDU_FAST_MULT_EN
                            r_acc <= {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`else
                            r_acc <= {{WIDTH{1'b0}}, w_mag_b};
                            r_opb <= w_mag_a;
`endif
                        end
                    end else if (bus.en && !bus.flush) begin
                        if (bus.funct == FUNCT_MTHI) r_hi <= bus.operand_1;
                        if (bus.funct == FUNCT_MTLO) r_lo <= bus.operand_1;
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= {w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0],
                              r_acc[WIDTH-2:0], w_div_ok};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: if (!bus.flush) begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed test-plan cases plus random ops vs. an arithmetic model.
module tb_mult_div_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32), .FUNCT_W(6)) bus ();
    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst(rst_n), .bus(bus.slave));

    function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f)
            F_MULT:  begin q = sa * sb; p = q; end
            F_MULTU: p = {32'd0, a} * {32'd0, b};
            F_DIV, F_DIVU: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (f == F_DIVU) p = {a % b, a / b};
                else begin
                    q = sa / sb; r = sa % sb;
                    qv = q; rv = r;
                    p = {rv[31:0], qv[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic int exp_stall(input logic [5:0] f, input logic [31:0] b);
        if (f == F_DIV || f == F_DIVU) return (b == 0) ? 1 : 33;
        if (f == F_MULT || f == F_MULTU) return MUL_STALL;
        return 0;
    endfunction

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
                0: return 32'h0000_0000;
                1: return 32'h0000_0001;
                2: return 32'h8000_0000;
                3: return 32'hFFFF_FFFF;
                default: return 32'h7FFF_FFFF;
            endcase
        end
        return $urandom;
    endfunction

    // Drives one instruction starting at posedge+1, returns the number of stalled cycles,
    // and leaves time at posedge+1 just after the instruction's last EX edge.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int stalls);
        bus.en = 1'b1; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.stall_req) break;
            stalls++;
        end
        @(posedge clk); #1;
        bus.en = 1'b0; bus.funct = '0;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.funct = F_MULT; bus.flush = 1'b0;
        bus.operand_1 = 32'h1234; bus.operand_2 = 32'h5678;
        rst_n = 1'b0;
        #12;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
        n_chk++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        n_chk++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        bus.en = 1'b0; bus.funct = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int s;
        logic [5:0] f;
        logic [31:0] a, b;
        logic [63:0] e;
        run_op(F_MULT, 32'hFFFF_FFFF, 32'h2, s);
        n_chk++; if (s !== MUL_STALL) begin n_err++; $display("FAIL mult_stall got=%0d exp=%0d", s, MUL_STALL); end
        n_chk++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mult_res got=%h_%h exp=ffffffff_fffffffe", bus.hi, bus.lo); end
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'h2, s);
        n_chk++; if ({bus.hi, bus.lo} !== 64'h0000_0001_FFFF_FFFE) begin n_err++; $display("FAIL multu_res got=%h_%h exp=00000001_fffffffe", bus.hi, bus.lo); end
        for (int i = 0; i < 12; i++) begin
            f = $urandom_range(0, 1) ? F_MULT : F_MULTU;
            a = rnd_val(); b = rnd_val(); e = ref_md(f, a, b);
            run_op(f, a, b, s);
            n_chk++; if (s !== exp_stall(f, b)) begin n_err++; $display("FAIL mul_rand_stall f=%h got=%0d exp=%0d", f, s, exp_stall(f, b)); end
            n_chk++; if ({bus.hi, bus.lo} !== e) begin n_err++; $display("FAIL mul_rand f=%h a=%h b=%h got=%h_%h exp=%h", f, a, b, bus.hi, bus.lo, e); end
        end
    endtask

    task automatic test_div();
        int s;
        logic [5:0] f;
        logic [31:0] a, b;
        logic [63:0] e;
        run_op(F_DIV, 32'hFFFF_FFF9, 32'h2, s);
        n_chk++; if (s !== 33) begin n_err++; $display("FAIL div_stall got=%0d exp=33", s); end
        n_chk++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_res got=%h_%h exp=ffffffff_fffffffd", bus.hi, bus.lo); end
        run_op(F_DIVU, 32'hFFFF_FFF9, 32'h2, s);
        n_chk++; if ({bus.hi, bus.lo} !== 64'h0000_0001_7FFF_FFFC) begin n_err++; $display("FAIL divu_res got=%h_%h exp=00000001_7ffffffc", bus.hi, bus.lo); end
        for (int i = 0; i < 12; i++) begin
            f = $urandom_range(0, 1) ? F_DIV : F_DIVU;
            a = rnd_val(); b = rnd_val();
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            e = ref_md(f, a, b);
            run_op(f, a, b, s);
            n_chk++; if (s !== exp_stall(f, b)) begin n_err++; $display("FAIL div_rand_stall f=%h got=%0d exp=%0d", f, s, exp_stall(f, b)); end
            n_chk++; if ({bus.hi, bus.lo} !== e) begin n_err++; $display("FAIL div_rand f=%h a=%h b=%h got=%h_%h exp=%h", f, a, b, bus.hi, bus.lo, e); end
        end
    endtask

    task automatic test_div_zero();
        int s;
        run_op(F_DIVU, 32'h5, 32'h0, s);
        n_chk++; if (s !== 1) begin n_err++; $display("FAIL divz_stall got=%0d exp=1", s); end
        n_chk++; if ({bus.hi, bus.lo} !== 64'h0000_0005_FFFF_FFFF) begin n_err++; $display("FAIL divz_res got=%h_%h exp=00000005_ffffffff", bus.hi, bus.lo); end
        run_op(F_DIV, 32'h8000_0000, 32'h0, s);
        n_chk++; if ({bus.hi, bus.lo} !== 64'h8000_0000_FFFF_FFFF) begin n_err++; $display("FAIL divz_s_res got=%h_%h exp=80000000_ffffffff", bus.hi, bus.lo); end
    endtask

    task automatic test_mthi_mtlo();
        int s;
        run_op(F_MTHI, 32'h1234_5678, 32'h0, s);
        n_chk++; if (s !== 0) begin n_err++; $display("FAIL mthi_stall got=%0d exp=0", s); end
        n_chk++; if (bus.hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi got=%h exp=12345678", bus.hi); end
        run_op(F_MTLO, 32'h9ABC_DEF0, 32'h0, s);
        n_chk++; if (s !== 0) begin n_err++; $display("FAIL mtlo_stall got=%0d exp=0", s); end
        n_chk++; if ({bus.hi, bus.lo} !== 64'h1234_5678_9ABC_DEF0) begin n_err++; $display("FAIL mtlo got=%h_%h exp=12345678_9abcdef0", bus.hi, bus.lo); end
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
        n_chk++; if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", bus.hi, bus.lo); end
    endtask

    task automatic test_flush();
        int s;
        run_op(F_MTHI, 32'hA5A5_A5A5, 32'h0, s);
        run_op(F_MTLO, 32'h5A5A_5A5A, 32'h0, s);
        bus.en = 1'b1; bus.funct = F_MULT; bus.operand_1 = 32'h3; bus.operand_2 = 32'h7;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.en = 1'b0; bus.funct = '0;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL flush_stall got=%b exp=0", bus.stall_req); end
        n_chk++; if ({bus.hi, bus.lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin n_err++; $display("FAIL flush_hilo got=%h_%h exp=a5a5a5a5_5a5a5a5a", bus.hi, bus.lo); end
        repeat (40) @(posedge clk);
        #1;
        n_chk++; if ({bus.hi, bus.lo} !== 64'hA5A5_A5A5_5A5A_5A5A) begin n_err++; $display("FAIL flush_late got=%h_%h exp=a5a5a5a5_5a5a5a5a", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            a = rnd_val(); b = rnd_val(); e = ref_md(F_MULTU, a, b);
            run_op(F_MULTU, a, b, s);
            n_chk++; if ({bus.hi, bus.lo} !== e) begin n_err++; $display("FAIL b2b_mul a=%h b=%h got=%h_%h exp=%h", a, b, bus.hi, bus.lo, e); end
            a = rnd_val(); b = rnd_val() | 32'h1; e = ref_md(F_DIV, a, b);
            run_op(F_DIV, a, b, s);
            run_op(F_MFHI, 32'h0, 32'h0, s);
            n_chk++; if (s !== 0) begin n_err++; $display("FAIL b2b_mfhi_stall got=%0d exp=0", s); end
            n_chk++; if ({bus.hi, bus.lo} !== e) begin n_err++; $display("FAIL b2b_div a=%h b=%h got=%h_%h exp=%h", a, b, bus.hi, bus.lo, e); end
        end
    endtask

    task automatic test_reset_mid();
        int s;
        run_op(F_MTHI, 32'hDEAD_BEEF, 32'h0, s);
        bus.en = 1'b1; bus.funct = F_DIVU; bus.operand_1 = 32'h1000; bus.operand_2 = 32'h3;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall_req); end
        n_chk++; if ({bus.hi, bus.lo} !== 64'h0) begin n_err++; $display("FAIL rstmid_hilo got=%h_%h exp=0", bus.hi, bus.lo); end
        bus.en = 1'b0; bus.funct = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(F_DIVU, 32'h1000, 32'h3, s);
        n_chk++; if ({bus.hi, bus.lo} !== 64'h0000_0001_0000_0555) begin n_err++; $display("FAIL rstmid_after got=%h_%h exp=00000001_00000555", bus.hi, bus.lo); end
    endtask

    initial begin
        bus.en = 1'b0; bus.funct = '0; bus.flush = 1'b0;
        bus.operand_1 = '0; bus.operand_2 = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
